// File: rtl/mem_sram_resp_pkg.sv
// Shared types and helpers for the data-side SRAM responder: size/response codes,
// FSM states, the latched request record and byte-lane mask helpers.
package mem_sram_resp_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_RESP_OKAY      = 2'b00,
    MEM_RESP_ERR_RANGE = 2'b10,
    MEM_RESP_ERR_ALIGN = 2'b11
  } mem_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_e;

  // Everything captured at accept; the error verdict is decided once and carried along.
  typedef struct packed {
    logic      write;
    addr_t     addr;
    mem_size_e size;
    data_t     wdata;
    mem_resp_e resp;
  } mem_req_t;

  function automatic logic [7:0] size_byte_mask(mem_size_e size);
    case (size)
      MEM_SIZE_B: return 8'h01;
      MEM_SIZE_H: return 8'h03;
      MEM_SIZE_W: return 8'h0F;
      default:    return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(mem_size_e size);
    case (size)
      MEM_SIZE_B: return 3'b000;
      MEM_SIZE_H: return 3'b001;
      MEM_SIZE_W: return 3'b011;
      default:    return 3'b111;
    endcase
  endfunction

  function automatic data_t expand_byte_mask(logic [7:0] be);
    data_t m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Single-port DEPTH x 64-bit storage with per-byte write enables and a
// registered read; read and write are never requested in the same cycle.
module mem_sram_bank
  import mem_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       be,
  input  data_t            wdata,
  output data_t            rdata
);

  data_t mem [DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would defeat RAM inference and
  // software must not rely on initial contents anyway.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata <= mem[idx];
    end
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_sram_resp.sv
// Data-bus responder serving a local scratchpad with a fixed wait-state count.
// Holds the request latch, error checks, lane alignment and the IDLE/WAIT/RESP FSM.
module mem_sram_resp
  import mem_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        req_i,
  input  logic [63:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] data_write_i,
  output logic        ready_o,
  output logic [63:0] data_read_o,
  output logic [1:0]  resp_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam addr_t       END_ADDR  = BASE_ADDR + addr_t'(DEPTH) * addr_t'(8);
  localparam logic [3:0]  LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_e state_q, state_d;
  logic [3:0] wait_cnt_q;
  mem_req_t   req_q;
  mem_size_e  size_in;
  mem_resp_e  acc_resp;
  logic       accept;

  addr_t            offset;
  logic [IDX_W-1:0] bank_idx;
  logic [7:0]       bank_be;
  data_t            bank_wdata;
  data_t            bank_rdata;
  logic             unused_offset_bits;

  assign size_in = mem_size_e'(size_i);
  assign accept  = (state_q == ST_IDLE) && valid_i;

  // Alignment outranks range: a misaligned out-of-range access reports ERR_ALIGN.
  always_comb begin
    acc_resp = MEM_RESP_OKAY;
    if ((addr_i[2:0] & align_mask(size_in)) != 3'b000) begin
      acc_resp = MEM_RESP_ERR_ALIGN;
    end else if ((addr_i < BASE_ADDR) || (addr_i >= END_ADDR)) begin
      acc_resp = MEM_RESP_ERR_RANGE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each always_comb assigns its outputs a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt_q == LAST_WAIT) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.write <= req_i;
      req_q.addr  <= addr_i;
      req_q.size  <= size_in;
      req_q.wdata <= data_write_i;
      req_q.resp  <= acc_resp;
    end
  end

  // The bank is read at the accept edge and written at the RESP edge, so the index
  // follows the live address in IDLE and the latched one in RESP.
  assign offset   = ((state_q == ST_RESP) ? req_q.addr : addr_i) - BASE_ADDR;
  assign bank_idx = offset[IDX_W+2:3];
  assign unused_offset_bits = ^{offset[ADDR_W-1:IDX_W+3], offset[2:0]};

  always_comb begin
    bank_be    = '0;
    bank_wdata = req_q.wdata << {req_q.addr[2:0], 3'b000};
    if ((state_q == ST_RESP) && req_q.write && (req_q.resp == MEM_RESP_OKAY)) begin
      bank_be = size_byte_mask(req_q.size) << req_q.addr[2:0];
    end
  end

  mem_sram_bank #(
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .rd_en (accept),
    .idx   (bank_idx),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Outputs are decoded from the state so an async reset clears them immediately.
  always_comb begin
    ready_o     = 1'b0;
    resp_o      = MEM_RESP_OKAY;
    data_read_o = '0;
    if (state_q == ST_RESP) begin
      ready_o = 1'b1;
      resp_o  = req_q.resp;
      if (!req_q.write && (req_q.resp == MEM_RESP_OKAY)) begin
        data_read_o = (bank_rdata >> {req_q.addr[2:0], 3'b000})
                    & expand_byte_mask(size_byte_mask(req_q.size));
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_resp.sv
// Self-checking bench for mem_sram_resp: directed scenarios plus random traffic on a
// LATENCY=2 and a LATENCY=0 instance, checked against a byte-addressed memory model.
module tb_mem_sram_resp;

  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] END_A = BASE + 64'(DEPTH) * 64'd8;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid [2];
  logic        req   [2];
  logic [63:0] addr  [2];
  logic [1:0]  size  [2];
  logic [63:0] wdata [2];
  logic        ready [2];
  logic [63:0] rdata [2];
  logic [1:0]  resp  [2];

  int checks = 0;
  int errors = 0;

  // Byte-addressed reference memory; key is {instance, byte address}.
  logic [7:0] bmem [bit [64:0]];

  mem_sram_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid[0]), .req_i(req[0]), .addr_i(addr[0]),
    .size_i(size[0]), .data_write_i(wdata[0]), .ready_o(ready[0]),
    .data_read_o(rdata[0]), .resp_o(resp[0])
  );

  mem_sram_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid[1]), .req_i(req[1]), .addr_i(addr[1]),
    .size_i(size[1]), .data_write_i(wdata[1]), .ready_o(ready[1]),
    .data_read_o(rdata[1]), .resp_o(resp[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] nb;
    nb = 64'd1 << sz;
    if ((a % nb) != 64'd0) return 2'b11;
    if ((a < BASE) || (a >= END_A)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [63:0] model_read(input bit d, input logic [63:0] a, input logic [1:0] sz);
    logic [63:0] v;
    bit [64:0]   k;
    v = '0;
    for (int i = 0; i < (1 << sz); i++) begin
      k = {d, a + 64'(i)};
      v[8*i +: 8] = bmem.exists(k) ? bmem[k] : 8'hxx;
    end
    return v;
  endfunction

  task automatic model_write(input bit d, input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      bmem[{d, a + 64'(i)}] = wd[8*i +: 8];
    end
  endtask

  // One transaction; consecutive calls present the next request in the cycle after ready.
  task automatic op(input int d, input bit wr, input logic [63:0] a, input logic [1:0] sz,
                    input logic [63:0] wd, input string tag, output logic [63:0] got);
    int          lat;
    int          el;
    logic [1:0]  er;
    logic [63:0] ed;
    er = model_resp(a, sz);
    ed = (!wr && er == 2'b00) ? model_read(d[0], a, sz) : 64'd0;
    el = (d == 0) ? int'(LAT_A) + 1 : int'(LAT_B) + 1;
    @(negedge clk);
    valid[d] = 1'b1; req[d] = wr; addr[d] = a; size[d] = sz; wdata[d] = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready[d] && lat < 40);
    check({tag, ".lat"}, 64'(lat), 64'(el));
    check({tag, ".resp"}, 64'(resp[d]), 64'(er));
    if (!wr) check({tag, ".data"}, rdata[d], ed);
    got = rdata[d];
    @(negedge clk);
    valid[d] = 1'b0;
    @(posedge clk); #1;
    check({tag, ".pulse"}, {61'd0, ready[d], resp[d]}, 64'd0);
    if (wr && er == 2'b00) model_write(d[0], a, sz, wd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] g;
    logic [63:0] a;
    logic        seen;
    int          r;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; req[d] = 1'b0; addr[d] = '0; size[d] = '0; wdata[d] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset.ready%0d", d), 64'(ready[d]), 64'd0);
      check($sformatf("reset.resp%0d", d), 64'(resp[d]), 64'd0);
      check($sformatf("reset.data%0d", d), rdata[d], 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Dword write and read-back.
    op(0, 1'b1, 64'h8000_0010, 2'b11, 64'h1122_3344_5566_7788, "t1.wr", g);
    op(0, 1'b0, 64'h8000_0010, 2'b11, 64'd0, "t1.rd", g);
    check("t1.value", g, 64'h1122_3344_5566_7788);

    // Byte lane write, dword and byte read-back.
    op(0, 1'b1, 64'h8000_0013, 2'b00, 64'h0000_0000_0000_00AB, "t2.wr", g);
    op(0, 1'b0, 64'h8000_0010, 2'b11, 64'd0, "t2.rd_d", g);
    check("t2.value_d", g, 64'h1122_3344_AB66_7788);
    op(0, 1'b0, 64'h8000_0013, 2'b00, 64'd0, "t2.rd_b", g);
    check("t2.value_b", g, 64'h0000_0000_0000_00AB);

    // Misalignment: no data, no write.
    op(0, 1'b0, 64'h8000_0011, 2'b01, 64'd0, "t3.rd_h", g);
    op(0, 1'b1, 64'h8000_0012, 2'b10, 64'hFFFF_FFFF, "t3.wr_w", g);
    op(0, 1'b0, 64'h8000_0010, 2'b11, 64'd0, "t3.rd_d", g);
    check("t3.value", g, 64'h1122_3344_AB66_7788);

    // Range edges.
    op(0, 1'b0, END_A, 2'b11, 64'd0, "t4.end", g);
    op(0, 1'b0, 64'h7FFF_FFF8, 2'b11, 64'd0, "t4.below", g);
    op(0, 1'b1, END_A - 64'd8, 2'b11, 64'hCAFE_F00D_0BAD_BEEF, "t4.last_wr", g);
    op(0, 1'b0, END_A - 64'd8, 2'b11, 64'd0, "t4.last_rd", g);
    check("t4.last_value", g, 64'hCAFE_F00D_0BAD_BEEF);

    // Reset while a write is waiting.
    op(0, 1'b1, 64'h8000_0020, 2'b11, 64'h0123_4567_89AB_CDEF, "t5.pre", g);
    @(negedge clk);
    valid[0] = 1'b1; req[0] = 1'b1; addr[0] = 64'h8000_0020; size[0] = 2'b11;
    wdata[0] = 64'h0000_0000_0000_DEAD;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("t5.ready", 64'(ready[0]), 64'd0);
    check("t5.resp", 64'(resp[0]), 64'd0);
    check("t5.data", rdata[0], 64'd0);
    @(negedge clk);
    valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ready[0];
    end
    check("t5.no_ready", 64'(seen), 64'd0);
    op(0, 1'b0, 64'h8000_0020, 2'b11, 64'd0, "t5.rd", g);
    check("t5.value", g, 64'h0123_4567_89AB_CDEF);
    op(0, 1'b1, 64'h8000_0020, 2'b11, 64'h0000_0000_0000_DEAD, "t5.next_wr", g);
    op(0, 1'b0, 64'h8000_0020, 2'b11, 64'd0, "t5.next_rd", g);
    check("t5.next_value", g, 64'h0000_0000_0000_DEAD);

    // Back-to-back on the zero-latency instance.
    op(1, 1'b1, 64'h8000_0008, 2'b11, 64'h5A5A_0000_1234_A5A5, "t6.wr", g);
    op(1, 1'b0, 64'h8000_0008, 2'b11, 64'd0, "t6.rd", g);
    check("t6.value", g, 64'h5A5A_0000_1234_A5A5);
    op(1, 1'b0, 64'h8000_000C, 2'b10, 64'd0, "t6.rd_w", g);
    check("t6.value_w", g, 64'h0000_0000_5A5A_0000);

    // Random traffic over a small window plus both out-of-range edges.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        op(d, 1'b1, BASE + 64'(8 * i), 2'b11, {$urandom, $urandom}, $sformatf("init%0d.%0d", d, i), g);
      end
      for (int i = 0; i < 60; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = BASE - 64'd8 + 64'($urandom_range(0, 7));
        else if (r == 1) a = END_A + 64'($urandom_range(0, 7));
        else             a = BASE + 64'($urandom_range(0, 63));
        op(d, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), {$urandom, $urandom},
           $sformatf("rnd%0d.%0d", d, i), g);
        if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
